// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_if
//  Description : Data-memory request/grant/response bus between the memory
//                stage (master) and the data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if #(
    parameter int D_WIDTH = 32
);
    logic               dmem_req;
    logic               dmem_we;
    logic [D_WIDTH-1:0] dmem_addr;
    logic [D_WIDTH-1:0] dmem_wdata;
    logic               dmem_gnt;
    logic               dmem_rvalid;
    logic [D_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_gnt,
        input  dmem_rvalid,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_gnt,
        output dmem_rvalid,
        output dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage. Issues word loads/stores over
//                a req/gnt/rvalid bus, stalls upstream while an access is
//                outstanding and holds the MEM/WB pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int D_WIDTH = 32,
    parameter int RF_SIZE = 5
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic [D_WIDTH-1:0] alu_out_mem,
    input  wire logic [D_WIDTH-1:0] rs2_val_mem,
    input  wire logic [RF_SIZE-1:0] rd_mem,
    input  wire logic               reg_write_mem,
    input  wire logic               mem_we_mem,
    input  wire logic               mem_re_mem,
    input  wire logic               mem_to_reg_mem,
    output logic                    stall,
    mem_stage_if.master             bus,
    output logic [D_WIDTH-1:0]      alu_out_wb,
    output logic [D_WIDTH-1:0]      load_data_wb,
    output logic [RF_SIZE-1:0]      rd_wb,
    output logic                    reg_write_wb,
    output logic                    mem_to_reg_wb,
    output logic                    misalign_wb
);

    localparam logic [1:0] c_IDLE = 2'd0;   // no access outstanding
    localparam logic [1:0] c_REQ  = 2'd1;   // request issued, waiting for gnt
    localparam logic [1:0] c_RESP = 2'd2;   // load granted, waiting for rvalid

    logic [1:0] r_state;
    logic [1:0] w_next_state;
    logic       w_mem_op;
    logic       w_misaligned;
    logic       w_access;
    logic       w_issue;
    logic       w_store_done;
    logic       w_load_done;
    logic       w_done;

    // Decode the access and derive the handshake/completion conditions
    always_comb begin
        w_mem_op     = mem_we_mem | mem_re_mem;
        w_misaligned = w_mem_op & (alu_out_mem[1:0] != 2'b00);
        w_access     = w_mem_op & ~w_misaligned;
        // A request is on the bus in IDLE (fresh access) or REQ (retrying)
        w_issue      = ((r_state == c_IDLE) & w_access) | (r_state == c_REQ);
        // Store wins when both we and re are set, so we alone marks a store
        w_store_done = w_issue & bus.dmem_gnt & mem_we_mem;
        w_load_done  = (r_state == c_RESP) & bus.dmem_rvalid;
        w_done       = w_store_done | w_load_done | ~w_access;
    end

    assign stall          = ~w_done;
    assign bus.dmem_req   = w_issue;
    assign bus.dmem_we    = mem_we_mem;
    assign bus.dmem_addr  = alu_out_mem;
    assign bus.dmem_wdata = rs2_val_mem;

    // Next-state selection; gnt/rvalid outside the expecting states are ignored
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_REQ: begin
                if (w_issue) begin
                    if (bus.dmem_gnt) begin
                        w_next_state = mem_we_mem ? c_IDLE : c_RESP;
                    end else begin
                        w_next_state = c_REQ;
                    end
                end
            end
            c_RESP: begin
                if (bus.dmem_rvalid) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // State register; reset abandons any outstanding access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // MEM/WB register: retire on completion, otherwise insert a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_out_wb    <= '0;
            load_data_wb  <= '0;
            rd_wb         <= '0;
            reg_write_wb  <= 1'b0;
            mem_to_reg_wb <= 1'b0;
            misalign_wb   <= 1'b0;
        end else if (w_done) begin
            alu_out_wb    <= alu_out_mem;
            rd_wb         <= rd_mem;
            mem_to_reg_wb <= mem_to_reg_mem;
            reg_write_wb  <= reg_write_mem & ~w_misaligned;
            misalign_wb   <= w_misaligned;
            if (w_load_done) begin
                load_data_wb <= bus.dmem_rdata;
            end
        end else begin
            reg_write_wb  <= 1'b0;
            misalign_wb   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int D_WIDTH = 32;
    localparam int RF_SIZE = 5;

    logic               clk = 1'b0;
    logic               rst;
    logic [D_WIDTH-1:0] alu_out_mem;
    logic [D_WIDTH-1:0] rs2_val_mem;
    logic [RF_SIZE-1:0] rd_mem;
    logic               reg_write_mem;
    logic               mem_we_mem;
    logic               mem_re_mem;
    logic               mem_to_reg_mem;
    logic               stall;
    logic [D_WIDTH-1:0] alu_out_wb;
    logic [D_WIDTH-1:0] load_data_wb;
    logic [RF_SIZE-1:0] rd_wb;
    logic               reg_write_wb;
    logic               mem_to_reg_wb;
    logic               misalign_wb;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if #(.D_WIDTH(D_WIDTH)) bus ();

    mem_stage #(
        .D_WIDTH (D_WIDTH),
        .RF_SIZE (RF_SIZE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alu_out_mem    (alu_out_mem),
        .rs2_val_mem    (rs2_val_mem),
        .rd_mem         (rd_mem),
        .reg_write_mem  (reg_write_mem),
        .mem_we_mem     (mem_we_mem),
        .mem_re_mem     (mem_re_mem),
        .mem_to_reg_mem (mem_to_reg_mem),
        .stall          (stall),
        .bus            (bus),
        .alu_out_wb     (alu_out_wb),
        .load_data_wb   (load_data_wb),
        .rd_wb          (rd_wb),
        .reg_write_wb   (reg_write_wb),
        .mem_to_reg_wb  (mem_to_reg_wb),
        .misalign_wb    (misalign_wb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] addr, input logic [31:0] data,
                          input logic [4:0] rd, input logic rw, input logic we,
                          input logic re, input logic m2r);
        alu_out_mem    = addr;
        rs2_val_mem    = data;
        rd_mem         = rd;
        reg_write_mem  = rw;
        mem_we_mem     = we;
        mem_re_mem     = re;
        mem_to_reg_mem = m2r;
    endtask

    task automatic check_wb_zero(input string tag);
        check({tag, "_alu_wb"},   alu_out_wb,    32'h0);
        check({tag, "_load_wb"},  load_data_wb,  32'h0);
        check({tag, "_rd_wb"},    rd_wb,         32'h0);
        check({tag, "_rw_wb"},    reg_write_wb,  32'h0);
        check({tag, "_m2r_wb"},   mem_to_reg_wb, 32'h0);
        check({tag, "_mis_wb"},   misalign_wb,   32'h0);
    endtask

    initial begin
        rst = 1'b1;
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b0;
        bus.dmem_rdata  = 32'h0;

        // Reset state
        repeat (3) tick();
        check_wb_zero("reset");
        check("reset_stall", stall, 32'h0);
        check("reset_req", bus.dmem_req, 32'h0);
        rst = 1'b0;

        // ALU op retires in one cycle
        set_op(32'h10, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        check("alu_stall", stall, 32'h0);
        check("alu_req", bus.dmem_req, 32'h0);
        tick();
        check("alu_out_wb", alu_out_wb, 32'h10);
        check("alu_rd_wb", rd_wb, 32'd3);
        check("alu_rw_wb", reg_write_wb, 32'h1);

        // Store with two wait states
        set_op(32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus.dmem_gnt = (i == 2);
            #3;
            check($sformatf("st_req%0d", i), bus.dmem_req, 32'h1);
            check($sformatf("st_we%0d", i), bus.dmem_we, 32'h1);
            check($sformatf("st_addr%0d", i), bus.dmem_addr, 32'h100);
            check($sformatf("st_wdata%0d", i), bus.dmem_wdata, 32'hDEAD_BEEF);
            check($sformatf("st_stall%0d", i), stall, (i < 2) ? 32'h1 : 32'h0);
            tick();
            check($sformatf("st_rw_wb%0d", i), reg_write_wb, 32'h0);
            check($sformatf("st_alu_wb%0d", i), alu_out_wb, (i < 2) ? 32'h10 : 32'h100);
        end
        bus.dmem_gnt = 1'b0;

        // Load, immediate gnt, rvalid three cycles later; stray gnt in RESP
        set_op(32'h200, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.dmem_gnt = 1'b1;
        #3;
        check("ld_req0", bus.dmem_req, 32'h1);
        check("ld_we0", bus.dmem_we, 32'h0);
        check("ld_stall0", stall, 32'h1);
        tick();
        check("ld_rw_wb0", reg_write_wb, 32'h0);
        for (int i = 1; i < 3; i++) begin
            bus.dmem_gnt   = (i == 1);
            bus.dmem_rdata = 32'hBAD0_0000 + i;
            #3;
            check($sformatf("ld_req%0d", i), bus.dmem_req, 32'h0);
            check($sformatf("ld_stall%0d", i), stall, 32'h1);
            tick();
            check($sformatf("ld_rw_wb%0d", i), reg_write_wb, 32'h0);
        end
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'h1234_5678;
        #3;
        check("ld_stall3", stall, 32'h0);
        tick();
        bus.dmem_rvalid = 1'b0;
        check("ld_data_wb", load_data_wb, 32'h1234_5678);
        check("ld_rd_wb", rd_wb, 32'd5);
        check("ld_rw_wb", reg_write_wb, 32'h1);
        check("ld_m2r_wb", mem_to_reg_wb, 32'h1);

        // Misaligned load retires at once with the misalign flag
        set_op(32'h203, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1);
        #3;
        check("mis_req", bus.dmem_req, 32'h0);
        check("mis_stall", stall, 32'h0);
        tick();
        check("mis_flag", misalign_wb, 32'h1);
        check("mis_rw_wb", reg_write_wb, 32'h0);
        check("mis_rd_wb", rd_wb, 32'd7);
        set_op(32'h44, 32'h0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        check("post_mis_flag", misalign_wb, 32'h0);
        check("post_mis_rw_wb", reg_write_wb, 32'h1);
        check("post_mis_alu_wb", alu_out_wb, 32'h44);

        // Reset while waiting for load data, then a stray rvalid
        set_op(32'h300, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.dmem_gnt = 1'b1;
        tick();
        bus.dmem_gnt = 1'b0;
        #2;
        check("rr_stall_resp", stall, 32'h1);
        rst = 1'b1;
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check_wb_zero("rr");
        check("rr_stall", stall, 32'h0);
        check("rr_req", bus.dmem_req, 32'h0);
        tick();
        rst = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hCAFE_F00D;
        #3;
        check("rr_stray_stall", stall, 32'h0);
        tick();
        bus.dmem_rvalid = 1'b0;
        check("rr_stray_load_wb", load_data_wb, 32'h0);
        check("rr_stray_rw_wb", reg_write_wb, 32'h0);

        // Back-to-back load then store, zero wait states
        set_op(32'h400, 32'h0, 5'd10, 1'b1, 1'b0, 1'b1, 1'b1);
        bus.dmem_gnt = 1'b1;
        #3;
        check("bb_ld_req", bus.dmem_req, 32'h1);
        check("bb_ld_we", bus.dmem_we, 32'h0);
        check("bb_ld_stall", stall, 32'h1);
        tick();
        bus.dmem_gnt    = 1'b0;
        bus.dmem_rvalid = 1'b1;
        bus.dmem_rdata  = 32'hA5A5_5A5A;
        #3;
        check("bb_ld_req_resp", bus.dmem_req, 32'h0);
        check("bb_ld_stall_resp", stall, 32'h0);
        tick();
        check("bb_ld_data_wb", load_data_wb, 32'hA5A5_5A5A);
        check("bb_ld_rd_wb", rd_wb, 32'd10);
        check("bb_ld_rw_wb", reg_write_wb, 32'h1);
        bus.dmem_rvalid = 1'b0;
        set_op(32'h404, 32'h1111_2222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.dmem_gnt = 1'b1;
        #3;
        check("bb_st_req", bus.dmem_req, 32'h1);
        check("bb_st_we", bus.dmem_we, 32'h1);
        check("bb_st_addr", bus.dmem_addr, 32'h404);
        check("bb_st_stall", stall, 32'h0);
        tick();
        bus.dmem_gnt = 1'b0;
        check("bb_st_rw_wb", reg_write_wb, 32'h0);
        check("bb_st_alu_wb", alu_out_wb, 32'h404);
        check("bb_st_load_hold", load_data_wb, 32'hA5A5_5A5A);
        set_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #3;
        check("bb_idle_req", bus.dmem_req, 32'h0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
